// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline register.
// Stall-bus driven hold/bubble/flush with optional one-entry skid slot.
module pipe_stage_buf #(
  parameter int WIDTH   = 32,
  parameter int STALL_W = 6,
  parameter int STAGE   = 2,
  parameter int SKID    = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic               skid_full_o,
  output logic               overrun_o,
  output logic [CNT_W-1:0]   hold_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  localparam bit HAS_SKID = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s_up;
  logic s_dn;
  logic stall_unused;

  assign s_up = stall[STAGE];
  assign s_dn = stall[STAGE+1];
  assign stall_unused = ^stall;

  logic             valid_q, valid_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             skid_v, skid_v_n;
  logic [WIDTH-1:0] skid_d, skid_d_n;
  logic             ovr_q, ovr_n;
  logic [CNT_W-1:0] hold_q, hold_n;
  logic [CNT_W-1:0] bub_q, bub_n;

  always_comb begin
    valid_n  = valid_q;
    data_n   = data_q;
    skid_v_n = skid_v;
    skid_d_n = skid_d;
    ovr_n    = ovr_q;
    hold_n   = hold_q;
    bub_n    = bub_q;
    priority case (1'b1)
      flush: begin
        valid_n  = 1'b0;
        data_n   = '0;
        skid_v_n = 1'b0;
        skid_d_n = '0;
      end
      s_dn: begin
        if (hold_q != CNT_MAX)
          hold_n = hold_q + CNT_ONE;
        // Only an unstalled upstream actually hands over its entry.
        if (!s_up && valid_i) begin
          if (HAS_SKID && !skid_v) begin
            skid_v_n = 1'b1;
            skid_d_n = data_i;
          end else begin
            ovr_n = 1'b1;
          end
        end
      end
      s_up: begin
        if (skid_v) begin
          valid_n  = 1'b1;
          data_n   = skid_d;
          skid_v_n = 1'b0;
        end else begin
          valid_n = 1'b0;
          data_n  = '0;
          if (bub_q != CNT_MAX)
            bub_n = bub_q + CNT_ONE;
        end
      end
      default: begin
        if (skid_v) begin
          valid_n  = 1'b1;
          data_n   = skid_d;
          skid_v_n = valid_i;
          skid_d_n = data_i;
        end else begin
          valid_n = valid_i;
          data_n  = data_i;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      skid_v  <= 1'b0;
      skid_d  <= '0;
      ovr_q   <= 1'b0;
      hold_q  <= '0;
      bub_q   <= '0;
    end else begin
      valid_q <= valid_n;
      data_q  <= data_n;
      skid_v  <= HAS_SKID ? skid_v_n : 1'b0;
      skid_d  <= HAS_SKID ? skid_d_n : '0;
      ovr_q   <= ovr_n;
      hold_q  <= hold_n;
      bub_q   <= bub_n;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign skid_full_o  = HAS_SKID ? skid_v : 1'b0;
  assign overrun_o    = ovr_q;
  assign hold_cnt_o   = hold_q;
  assign bubble_cnt_o = bub_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a SKID=1 instance and a SKID=0/CNT_W=2
// instance share one stimulus stream; rows are checked via a queue.
module tb_pipe_stage_buf;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic        valid_i;
  logic [31:0] data_i;

  logic        v1, sk1, ov1;
  logic [31:0] d1;
  logic [15:0] h1, b1;
  logic        v0, sk0, ov0;
  logic [31:0] d0;
  logic [1:0]  h0, b0;

  int checks = 0;
  int errors = 0;

  logic [34:0] sbq[$];

  always #5 clock = ~clock;

  pipe_stage_buf #(
    .WIDTH(32), .STALL_W(6), .STAGE(2), .SKID(1), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_i(valid_i), .data_i(data_i),
    .valid_o(v1), .data_o(d1), .skid_full_o(sk1),
    .overrun_o(ov1), .hold_cnt_o(h1), .bubble_cnt_o(b1)
  );

  pipe_stage_buf #(
    .WIDTH(32), .STALL_W(6), .STAGE(2), .SKID(0), .CNT_W(2)
  ) dut0 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_i(valid_i), .data_i(data_i),
    .valid_o(v0), .data_o(d0), .skid_full_o(sk0),
    .overrun_o(ov0), .hold_cnt_o(h0), .bubble_cnt_o(b0)
  );

  task automatic cycle(input logic [5:0] st, input logic vi,
                       input logic [31:0] di, input logic fl);
    @(negedge clock);
    stall = st; valid_i = vi; data_i = di; flush = fl;
    @(posedge clock); #1;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1; stall = '0; flush = 1'b0;
    valid_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1; stall = '0; flush = 1'b0;
    valid_i = 1'b1; data_i = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({v1, d1, sk1, ov1, h1, b1} !== 67'd0) begin
        errors++;
        $display("FAIL reset_dut got v=%b d=%h sk=%b ov=%b h=%0d b=%0d need all 0",
                 v1, d1, sk1, ov1, h1, b1);
      end
      checks++;
      if ({v0, d0, sk0, ov0, h0, b0} !== 39'd0) begin
        errors++;
        $display("FAIL reset_dut0 got v=%b d=%h ov=%b need all 0", v0, d0, ov0);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({v1, d1} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL pass_through got v=%b d=%h need v=1 d=deadbeef", v1, d1);
    end
    checks++;
    if ({v0, d0} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL pass_through0 got v=%b d=%h need v=1 d=deadbeef", v0, d0);
    end
  endtask

  task automatic test_bubble;
    logic [34:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) sbq.push_back({1'b1, 32'h11, 2'b00});
      else        sbq.push_back({1'b0, 32'h0, 2'b00});
      cycle(i == 0 ? 6'b000000 : 6'b000100, 1'b1, 32'h11 + i, 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({v1, d1, sk1, ov1} !== e) begin
        errors++;
        $display("FAIL bubble[%0d] got %h need %h", i, {v1, d1, sk1, ov1}, e);
      end
    end
    checks++;
    if ({b1, h1} !== {16'd3, 16'd0}) begin
      errors++;
      $display("FAIL bubble_cnt got b=%0d h=%0d need b=3 h=0", b1, h1);
    end
  endtask

  task automatic test_hold;
    logic [34:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sbq.push_back({1'b1, 32'h22, 2'b00});
      cycle(i == 0 ? 6'b000000 : 6'b001100, 1'b1, 32'h22 + i, 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({v1, d1, sk1, ov1} !== e) begin
        errors++;
        $display("FAIL hold[%0d] got %h need %h", i, {v1, d1, sk1, ov1}, e);
      end
    end
    checks++;
    if ({h1, b1} !== {16'd4, 16'd0}) begin
      errors++;
      $display("FAIL hold_cnt got h=%0d b=%0d need h=4 b=0", h1, b1);
    end
  endtask

  task automatic test_skid;
    logic [5:0]  st [4];
    logic        vi [4];
    logic [31:0] di [4];
    logic [34:0] ex [4];
    logic        o0 [4];
    logic [34:0] e;
    st = '{6'b000000, 6'b001000, 6'b000000, 6'b000000};
    vi = '{1'b1, 1'b1, 1'b1, 1'b0};
    di = '{32'h10, 32'h33, 32'h44, 32'h55};
    ex = '{{1'b1, 32'h10, 2'b00}, {1'b1, 32'h10, 2'b10},
           {1'b1, 32'h33, 2'b10}, {1'b1, 32'h44, 2'b00}};
    o0 = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(ex[i]);
      cycle(st[i], vi[i], di[i], 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({v1, d1, sk1, ov1} !== e) begin
        errors++;
        $display("FAIL skid[%0d] got %h need %h", i, {v1, d1, sk1, ov1}, e);
      end
      checks++;
      if ({ov0, sk0} !== {o0[i], 1'b0}) begin
        errors++;
        $display("FAIL skid0_ovr[%0d] got ov=%b sk=%b need ov=%b sk=0",
                 i, ov0, sk0, o0[i]);
      end
    end
  endtask

  task automatic test_overrun;
    logic [5:0]  st [4];
    logic        vi [4];
    logic [31:0] di [4];
    logic [34:0] ex [4];
    logic [34:0] e;
    st = '{6'b001000, 6'b001000, 6'b000000, 6'b000000};
    vi = '{1'b1, 1'b1, 1'b0, 1'b0};
    di = '{32'hA1, 32'hA2, 32'h0, 32'h0};
    ex = '{{1'b0, 32'h0, 2'b10}, {1'b0, 32'h0, 2'b11},
           {1'b1, 32'hA1, 2'b01}, {1'b0, 32'h0, 2'b01}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(ex[i]);
      cycle(st[i], vi[i], di[i], 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({v1, d1, sk1, ov1} !== e) begin
        errors++;
        $display("FAIL overrun[%0d] got %h need %h", i, {v1, d1, sk1, ov1}, e);
      end
      checks++;
      if (ov0 !== 1'b1) begin
        errors++;
        $display("FAIL overrun0[%0d] got %b need 1", i, ov0);
      end
    end
    do_reset();
    checks++;
    if ({ov1, ov0} !== 2'b00) begin
      errors++;
      $display("FAIL overrun_clear got %b%b need 00", ov1, ov0);
    end
  endtask

  task automatic test_flush;
    logic [34:0] e;
    do_reset();
    sbq.push_back({1'b1, 32'h66, 2'b00});
    cycle(6'b000000, 1'b1, 32'h66, 1'b0);
    sbq.push_back({1'b1, 32'h66, 2'b10});
    cycle(6'b001000, 1'b1, 32'h77, 1'b0);
    sbq.push_back({1'b0, 32'h0, 2'b00});
    cycle(6'b001000, 1'b1, 32'h88, 1'b1);
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      if (i == 2) begin
        checks++;
        if ({v1, d1, sk1, ov1} !== e) begin
          errors++;
          $display("FAIL flush got %h need %h", {v1, d1, sk1, ov1}, e);
        end
      end
    end
    checks++;
    if ({h1, b1, ov0, h0} !== {16'd1, 16'd0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL flush_keep got h=%0d b=%0d ov0=%b h0=%0d need 1 0 1 1",
               h1, b1, ov0, h0);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    repeat (6) cycle(6'b001100, 1'b1, 32'h5A, 1'b0);
    checks++;
    if (h0 !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold0 got %0d need 3", h0);
    end
    checks++;
    if (h1 !== 16'd6) begin
      errors++;
      $display("FAIL sat_hold got %0d need 6", h1);
    end
    repeat (5) cycle(6'b000100, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({b0, h0} !== {2'd3, 2'd3}) begin
      errors++;
      $display("FAIL sat_bub0 got b=%0d h=%0d need b=3 h=3", b0, h0);
    end
  endtask

  task automatic test_back_to_back;
    logic        vi;
    logic [31:0] di;
    logic [34:0] e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      vi = 1'($urandom_range(0, 1));
      di = $urandom;
      sbq.push_back({vi, di, 2'b00});
      cycle(6'b000000, vi, di, 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({v1, d1, sk1, ov1} !== e) begin
        errors++;
        $display("FAIL b2b[%0d] got %h need %h", i, {v1, d1, sk1, ov1}, e);
      end
    end
    checks++;
    if ({h1, b1} !== 32'd0) begin
      errors++;
      $display("FAIL b2b_cnt got h=%0d b=%0d need 0 0", h1, b1);
    end
  endtask

  initial begin
    reset = 1'b1; stall = '0; flush = 1'b0;
    valid_i = 1'b0; data_i = '0;
    test_reset();
    test_bubble();
    test_hold();
    test_skid();
    test_overrun();
    test_flush();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register; successor to the fixed-field ID/EX register.
- Carries an opaque WIDTH-bit payload plus a valid bit between stage STAGE and STAGE+1, driven by the global stall bus.
- Adds flush, an optional one-entry skid slot for non-monotone stall patterns, a sticky overrun flag and saturating hold/bubble performance counters.
- Instantiated once per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with payloads packed and unpacked by the stage.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- STALL_W, 6, width of the stall bus.
- STAGE, 2, index of the upstream stage in the stall bus; requires STAGE+1 < STALL_W.
- SKID, 0, 1 enables the one-entry skid slot; 0 means no skid storage.
- CNT_W, 16, width of each performance counter.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  STALL_W  global stall bus; s_up = stall[STAGE], s_dn = stall[STAGE+1].
- flush  in  1  kill the in-flight entry (branch redirect).
- valid_i  in  1  upstream entry valid.
- data_i  in  WIDTH  upstream payload.
- valid_o  out  1  registered valid to the downstream stage.
- data_o  out  WIDTH  registered payload to the downstream stage.
- skid_full_o  out  1  skid slot occupied; constant 0 when SKID=0.
- overrun_o  out  1  sticky: a valid entry was dropped.
- hold_cnt_o  out  CNT_W  cycles spent holding (s_dn=1), saturating.
- bubble_cnt_o  out  CNT_W  bubbles inserted, saturating.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: all outputs, the skid slot and its payload clear to 0.
- Latency: 1 cycle from data_i to data_o when unstalled. All outputs are registered.
- Priority per cycle: reset > flush > stall cases below.
- Flush (no reset): valid_o<=0, data_o<=0, skid cleared.
  - Counters and overrun_o are unchanged.
  - Flush wins even if s_dn=1.
- Case A, s_dn=1 (hold):
  - data_o and valid_o hold their values.
  - hold_cnt increments.
  - If s_up=0 and valid_i=1: with SKID=1 and the skid empty, capture data_i into the skid.
  - Otherwise the entry is dropped and overrun_o<=1.
- Case B, s_dn=0, s_up=1:
  - If the skid is full, output the skid entry (valid_o<=1) and empty the skid.
  - Otherwise insert a bubble: data_o<=0, valid_o<=0, bubble_cnt increments.
- Case C, s_dn=0, s_up=0:
  - If the skid is full, output the skid entry. The skid is then refilled with data_i if valid_i=1, otherwise emptied. Nothing is dropped.
  - If the skid is empty: data_o<=data_i, valid_o<=valid_i.
- Counters saturate at 2^CNT_W-1 and never wrap. They clear only on reset.
- overrun_o is sticky until reset.
- SKID=0: skid_full_o is tied to 0. Case A with s_up=0 and valid_i=1 always sets overrun_o. This cannot occur with a monotone stall bus.
- Ordering: skid contents are always older than data_i and are emitted first.

Test Plan:
1. Reset and pass-through: assert reset for 2 cycles, then stall=0, valid_i=1, data_i=0xDEADBEEF -> valid_o=0 and data_o=0 during reset; one cycle after release, valid_o=1 and data_o=0xDEADBEEF.
2. Bubble: data_o=0x11 held, stall=6'b000100 (STAGE=2) for 3 cycles -> data_o=0, valid_o=0 each cycle; bubble_cnt_o=3; hold_cnt_o=0.
3. Hold: stall=6'b001100 for 4 cycles with data_o=0x22 -> data_o stays 0x22, valid_o=1, hold_cnt_o=4, bubble_cnt_o=0.
4. Skid with SKID=1:
   - Cycle 1: stall=6'b001000, valid_i=1, data_i=0x33 -> skid_full_o=1, data_o held.
   - Cycle 2: stall=0, data_i=0x44 -> data_o=0x33, skid holds 0x44.
   - Cycle 3: stall=0, valid_i=0 -> data_o=0x44, skid_full_o=0.
   - overrun_o stays 0 throughout.
5. Overrun with SKID=0: stall=6'b001000, valid_i=1 -> overrun_o=1 next cycle and remains 1 after stall clears, until reset.
6. Flush and saturation:
   - Flush with s_dn=1 and the skid full -> valid_o=0, data_o=0, skid_full_o=0; counters unchanged.
   - With CNT_W=2, hold for 6 cycles -> hold_cnt_o=3.
